// File: rtl/pipe_pkg.sv
// Shared pipeline types for the MEM stage: FSM encoding, MEM/WB bundle,
// bubble control constants and the word-alignment helper.
package pipe_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } mem_state_e;

    localparam logic BUBBLE_REGWRITE = 1'b0;
    localparam logic BUBBLE_MEMTOREG = 1'b0;

    typedef struct packed {
        logic [XLEN-1:0]       readdata;
        logic [XLEN-1:0]       aluresult;
        logic [REG_ADDR_W-1:0] write_address;
        logic                  regwrite_en;
        logic                  memtoreg;
    } mem_wb_t;

    function automatic logic misaligned_word(input logic [XLEN-1:0] addr);
        return addr[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register; a bubble clears only the control bits
// so the data fields keep their last committed values.
module mem_wb_reg
    import pipe_pkg::*;
(
    input  logic    clk,
    input  logic    reset,
    input  logic    bubble,
    input  mem_wb_t d,
    output mem_wb_t q
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q <= '0;
        end else if (bubble) begin
            q.regwrite_en <= BUBBLE_REGWRITE;
            q.memtoreg    <= BUBBLE_MEMTOREG;
        end else begin
            q <= d;
        end
    end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM stage: word load/store over a req/ready handshake with bounded
// wait states, upstream stall, branch resolve and the MEM/WB register.
module mem_wb_stage
    import pipe_pkg::*;
#(
    parameter int MAX_WAIT = 8,
    parameter int CNT_W    = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [XLEN-1:0]       pc_in,
    input  logic                  zero_in,
    input  logic [XLEN-1:0]       aluresult_in,
    input  logic [XLEN-1:0]       data_b_in,
    input  logic [REG_ADDR_W-1:0] write_address_in,
    input  logic                  branch_in,
    input  logic                  Memwrite_in,
    input  logic                  MemRead_in,
    input  logic                  regwrite_en_in,
    input  logic                  MemtoReg_in,
    output logic                  dmem_req,
    output logic                  dmem_we,
    output logic [XLEN-1:0]       dmem_addr,
    output logic [XLEN-1:0]       dmem_wdata,
    input  logic [XLEN-1:0]       dmem_rdata,
    input  logic                  dmem_ready,
    output logic                  stall_out,
    output logic                  pcsrc,
    output logic [XLEN-1:0]       branch_target,
    output logic                  mem_err,
    output logic [XLEN-1:0]       readdata_out,
    output logic [XLEN-1:0]       aluresult_out,
    output logic [REG_ADDR_W-1:0] write_address_out,
    output logic                  regwrite_en_out,
    output logic                  MemtoReg_out
);

    mem_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             mem_op;
    logic             misaligned;
    logic             is_load;
    logic             timeout;
    logic             bubble;
    logic             set_err;
    mem_wb_t          wb_d, wb_q;

    assign mem_op     = MemRead_in | Memwrite_in;
    assign is_load    = MemRead_in & ~Memwrite_in;
    assign misaligned = mem_op & misaligned_word(aluresult_in);
    assign timeout    = (state_q == WAIT) &&
                        (cnt_q == CNT_W'(MAX_WAIT - 1));

    // Gating with reset drops the request the moment reset asserts.
    assign dmem_req   = mem_op & ~misaligned & reset;
    assign dmem_we    = Memwrite_in;
    assign dmem_addr  = aluresult_in;
    assign dmem_wdata = data_b_in;

    assign stall_out     = dmem_req & ~dmem_ready & ~timeout;
    assign pcsrc         = branch_in & zero_in & ~stall_out;
    assign branch_target = pc_in;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bubble  = 1'b0;
        set_err = 1'b0;
        unique case (state_q)
            IDLE: begin
                unique case (1'b1)
                    misaligned: begin
                        bubble  = 1'b1;
                        set_err = 1'b1;
                    end
                    (dmem_req && !dmem_ready): begin
                        state_d = WAIT;
                        cnt_d   = '0;
                        bubble  = 1'b1;
                    end
                    default: ;
                endcase
            end
            WAIT: begin
                unique case (1'b1)
                    dmem_ready: begin
                        state_d = IDLE;
                    end
                    (timeout && !dmem_ready): begin
                        state_d = IDLE;
                        bubble  = 1'b1;
                        set_err = 1'b1;
                    end
                    default: begin
                        cnt_d  = cnt_q + CNT_W'(1);
                        bubble = 1'b1;
                    end
                endcase
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            mem_err <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (set_err) mem_err <= 1'b1;
        end
    end

    // Stores never write back, regardless of the upstream control bit.
    always_comb begin
        wb_d               = '0;
        wb_d.readdata      = is_load ? dmem_rdata : '0;
        wb_d.aluresult     = aluresult_in;
        wb_d.write_address = write_address_in;
        wb_d.regwrite_en   = regwrite_en_in & ~Memwrite_in;
        wb_d.memtoreg      = MemtoReg_in;
    end

    mem_wb_reg u_mem_wb_reg (
        .clk    (clk),
        .reset  (reset),
        .bubble (bubble),
        .d      (wb_d),
        .q      (wb_q)
    );

    assign readdata_out      = wb_q.readdata;
    assign aluresult_out     = wb_q.aluresult;
    assign write_address_out = wb_q.write_address;
    assign regwrite_en_out   = wb_q.regwrite_en;
    assign MemtoReg_out      = wb_q.memtoreg;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Scoreboard bench for mem_wb_stage: a per-instruction cycle model
// pushes expectations, a negedge monitor pops and compares them.
module tb_mem_wb_stage;

    localparam int MAXW  = 8;
    localparam int NEVER = 255;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc_in, aluresult_in, data_b_in, dmem_rdata;
    logic [4:0]  write_address_in;
    logic        zero_in, branch_in, Memwrite_in, MemRead_in;
    logic        regwrite_en_in, MemtoReg_in, dmem_ready;
    logic        dmem_req, dmem_we, stall_out, pcsrc, mem_err;
    logic [31:0] dmem_addr, dmem_wdata, branch_target;
    logic [31:0] readdata_out, aluresult_out;
    logic [4:0]  write_address_out;
    logic        regwrite_en_out, MemtoReg_out;

    mem_wb_stage #(.MAX_WAIT(MAXW), .CNT_W(8)) dut (
        .clk               (clk),
        .reset             (reset),
        .pc_in             (pc_in),
        .zero_in           (zero_in),
        .aluresult_in      (aluresult_in),
        .data_b_in         (data_b_in),
        .write_address_in  (write_address_in),
        .branch_in         (branch_in),
        .Memwrite_in       (Memwrite_in),
        .MemRead_in        (MemRead_in),
        .regwrite_en_in    (regwrite_en_in),
        .MemtoReg_in       (MemtoReg_in),
        .dmem_req          (dmem_req),
        .dmem_we           (dmem_we),
        .dmem_addr         (dmem_addr),
        .dmem_wdata        (dmem_wdata),
        .dmem_rdata        (dmem_rdata),
        .dmem_ready        (dmem_ready),
        .stall_out         (stall_out),
        .pcsrc             (pcsrc),
        .branch_target     (branch_target),
        .mem_err           (mem_err),
        .readdata_out      (readdata_out),
        .aluresult_out     (aluresult_out),
        .write_address_out (write_address_out),
        .regwrite_en_out   (regwrite_en_out),
        .MemtoReg_out      (MemtoReg_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        req, stall, pcsrc, we;
        logic [31:0] addr, wdata, target;
        logic [31:0] rd, alu;
        logic [4:0]  wa;
        logic        rw, m2r, err;
    } exp_t;

    exp_t        q[$];
    exp_t        pend;
    bit          have_pend = 0;
    bit          mon_en = 0;
    int          n_tests = 0;
    int          n_fail = 0;

    // Architectural model state: last committed MEM/WB data and sticky error.
    logic [31:0] m_rd = 0, m_alu = 0;
    logic [4:0]  m_wa = 0;
    logic        m_err = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (have_pend) begin
                    chk("readdata_out", readdata_out, pend.rd);
                    chk("aluresult_out", aluresult_out, pend.alu);
                    chk("write_address_out", {27'd0, write_address_out}, {27'd0, pend.wa});
                    chk("regwrite_en_out", {31'd0, regwrite_en_out}, {31'd0, pend.rw});
                    chk("MemtoReg_out", {31'd0, MemtoReg_out}, {31'd0, pend.m2r});
                    chk("mem_err", {31'd0, mem_err}, {31'd0, pend.err});
                    have_pend = 0;
                end
                if (q.size() > 0) begin
                    pend = q.pop_front();
                    have_pend = 1;
                    chk("dmem_req", {31'd0, dmem_req}, {31'd0, pend.req});
                    chk("stall_out", {31'd0, stall_out}, {31'd0, pend.stall});
                    chk("pcsrc", {31'd0, pcsrc}, {31'd0, pend.pcsrc});
                    chk("branch_target", branch_target, pend.target);
                    if (pend.req) begin
                        chk("dmem_we", {31'd0, dmem_we}, {31'd0, pend.we});
                        chk("dmem_addr", dmem_addr, pend.addr);
                        chk("dmem_wdata", dmem_wdata, pend.wdata);
                    end
                end
            end
        end
    end

    // One instruction held at the stage until it leaves; d is the number of
    // not-ready cycles before memory answers (NEVER = no answer).
    task automatic run_instr(input logic [31:0] alu, input logic [31:0] b,
                             input logic [4:0] wa, input logic rd,
                             input logic wr, input logic rw, input logic m2r,
                             input logic br, input logic z,
                             input logic [31:0] pc, input int d);
        int   k = 0;
        bit   done = 0;
        logic mem, mis, rdy;
        logic [31:0] rdata;
        exp_t e;
        while (!done) begin
            @(posedge clk);
            #1;
            mem   = rd | wr;
            mis   = mem && (alu[1:0] != 2'b00);
            rdata = $urandom;
            rdy   = (mem && !mis) ? (k == d) : 1'($urandom_range(0, 1));
            aluresult_in = alu; data_b_in = b; write_address_in = wa;
            MemRead_in = rd; Memwrite_in = wr; regwrite_en_in = rw;
            MemtoReg_in = m2r; branch_in = br; zero_in = z; pc_in = pc;
            dmem_rdata = rdata; dmem_ready = rdy;
            e = '{default: '0};
            e.we = wr; e.addr = alu; e.wdata = b; e.target = pc;
            e.req = mem && !mis;
            e.stall = e.req && (k != d) && (k != MAXW);
            if (!mem || (e.req && k == d)) begin
                m_rd  = (rd && !wr) ? rdata : 32'd0;
                m_alu = alu;
                m_wa  = wa;
                e.rw  = rw && !wr;
                e.m2r = m2r;
                done  = 1;
            end else begin
                if (mis || k == MAXW) begin
                    m_err = 1;
                    done  = 1;
                end
            end
            e.rd = m_rd; e.alu = m_alu; e.wa = m_wa; e.err = m_err;
            e.pcsrc = br && z && !e.stall;
            q.push_back(e);
            k++;
        end
    endtask

    initial begin
        int kind, r, dly;
        logic [31:0] a;
        logic rdb, wrb;
        reset = 0; pc_in = 0; zero_in = 0; aluresult_in = 0;
        data_b_in = 0; write_address_in = 0; branch_in = 0;
        Memwrite_in = 0; MemRead_in = 0; regwrite_en_in = 0;
        MemtoReg_in = 0; dmem_rdata = 0; dmem_ready = 0;
        repeat (2) @(negedge clk);
        chk("rst readdata_out", readdata_out, 32'd0);
        chk("rst aluresult_out", aluresult_out, 32'd0);
        chk("rst write_address_out", {27'd0, write_address_out}, 32'd0);
        chk("rst regwrite_en_out", {31'd0, regwrite_en_out}, 32'd0);
        chk("rst MemtoReg_out", {31'd0, MemtoReg_out}, 32'd0);
        chk("rst mem_err", {31'd0, mem_err}, 32'd0);
        chk("rst dmem_req", {31'd0, dmem_req}, 32'd0);
        reset = 1;
        mon_en = 1;

        run_instr(32'h1234, 32'h0, 5'd5, 0, 0, 1, 0, 0, 0, 32'h0, 0);
        run_instr(32'h40, 32'h0, 5'd6, 1, 0, 1, 1, 0, 0, 32'h0, 0);
        run_instr(32'h44, 32'hCAFE_F00D, 5'd7, 0, 1, 1, 0, 0, 0, 32'h0, 3);
        run_instr(32'h48, 32'h0, 5'd8, 1, 0, 1, 1, 0, 0, 32'h0, NEVER);
        run_instr(32'h2000, 32'h0, 5'd9, 0, 0, 1, 0, 0, 0, 32'h0, 0);
        run_instr(32'h42, 32'h0, 5'd10, 1, 0, 1, 1, 0, 0, 32'h0, 0);
        run_instr(32'h0, 32'h0, 5'd0, 0, 0, 0, 0, 1, 1, 32'h100, 0);
        run_instr(32'h50, 32'h0, 5'd11, 1, 0, 1, 1, 1, 1, 32'h200, MAXW);

        for (int i = 0; i < 300; i++) begin
            kind = $urandom_range(0, 9);
            r    = $urandom_range(0, 9);
            if (r < 4) dly = 0;
            else if (r < 8) dly = $urandom_range(1, MAXW - 1);
            else if (r == 8) dly = MAXW;
            else dly = NEVER;
            a = $urandom;
            rdb = 0; wrb = 0;
            if (kind <= 3) begin
                rdb = 0; wrb = 0;
            end else if (kind <= 6) begin
                rdb = 1; a = a & 32'hFFFF_FFFC;
            end else if (kind <= 8) begin
                wrb = 1; rdb = 1'($urandom_range(0, 1));
                a = a & 32'hFFFF_FFFC;
            end else begin
                rdb = 1'($urandom_range(0, 1)); wrb = ~rdb;
                a = (a & 32'hFFFF_FFFC) | 32'($urandom_range(1, 3));
            end
            run_instr(a, $urandom, 5'($urandom), rdb, wrb,
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      $urandom, dly);
        end

        for (int i = 0; i < 6 && (q.size() > 0 || have_pend); i++)
            @(negedge clk);
        if (q.size() > 0 || have_pend) begin
            n_tests++; n_fail++;
            $display("FAIL drain: %0d entries left, expected 0", q.size());
        end
        mon_en = 0;

        // Reset asserted while a load sits in WAIT.
        @(posedge clk);
        #1;
        aluresult_in = 32'h80; MemRead_in = 1; Memwrite_in = 0;
        regwrite_en_in = 1; MemtoReg_in = 1; dmem_ready = 0;
        branch_in = 0; zero_in = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("wait stall_out", {31'd0, stall_out}, 32'd1);
        reset = 0;
        #1;
        chk("midrst dmem_req", {31'd0, dmem_req}, 32'd0);
        chk("midrst stall_out", {31'd0, stall_out}, 32'd0);
        chk("midrst mem_err", {31'd0, mem_err}, 32'd0);
        chk("midrst readdata_out", readdata_out, 32'd0);
        chk("midrst aluresult_out", aluresult_out, 32'd0);
        chk("midrst write_address_out", {27'd0, write_address_out}, 32'd0);
        chk("midrst regwrite_en_out", {31'd0, regwrite_en_out}, 32'd0);
        chk("midrst MemtoReg_out", {31'd0, MemtoReg_out}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- Pipeline MEM stage of the 5-stage RISC-V core, directly downstream of EX_MEM_Register; consumes its outputs and owns the MEM/WB pipeline register.
- Performs the word load/store against a data memory with a req/ready handshake, tolerates wait states with a bounded timeout, and stalls upstream while busy.
- Resolves branch-taken (pcsrc) for the fetch stage.

Parameters:
- MAX_WAIT, 8, maximum WAIT-state cycles before a memory access is aborted; legal range 2..255.
- CNT_W, 8, width of the wait counter; must hold MAX_WAIT.

Ports:
- clk  in  1  pipeline clock, rising edge.
- reset  in  1  asynchronous, active-low reset; 0 resets the block.
- pc_in  in  32  branch target from EX/MEM.
- zero_in  in  1  ALU zero flag.
- aluresult_in  in  32  ALU result / memory address.
- data_b_in  in  32  store data.
- write_address_in  in  5  destination register.
- branch_in, Memwrite_in, MemRead_in, regwrite_en_in, MemtoReg_in  in  1 each  control bits from EX/MEM.
- dmem_req  out  1  memory request valid.
- dmem_we  out  1  1 = store, 0 = load.
- dmem_addr  out  32  word-aligned byte address.
- dmem_wdata  out  32  store data.
- dmem_rdata  in  32  load data, valid when dmem_ready=1.
- dmem_ready  in  1  completes the request in the same cycle.
- stall_out  out  1  freeze PC, IF/ID, ID/EX and EX/MEM.
- pcsrc  out  1  branch taken.
- branch_target  out  32  equals pc_in.
- mem_err  out  1  sticky error: misaligned access or timeout.
- readdata_out, aluresult_out  out  32  MEM/WB data.
- write_address_out  out  5  MEM/WB destination register.
- regwrite_en_out, MemtoReg_out  out  1  MEM/WB control.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, cnt=0, mem_err=0. All registered outputs are 0: readdata_out, aluresult_out, write_address_out, regwrite_en_out, MemtoReg_out. Reset mid-access drops the request immediately, with no completion.
- mem_op = MemRead_in | Memwrite_in. Memwrite_in has priority if both bits are set.
- misaligned = mem_op & (aluresult_in[1:0] != 0).
- pcsrc = branch_in & zero_in & ~stall_out (combinational). branch_target = pc_in.
- dmem_addr = aluresult_in, dmem_wdata = data_b_in, dmem_we = Memwrite_in. These pass through combinationally; the upstream stage is frozen by stall_out, so the inputs are stable.
- dmem_req = mem_op & ~misaligned & (state==IDLE | state==WAIT).
- stall_out = dmem_req & ~dmem_ready & ~timeout, where timeout = (state==WAIT) & (cnt==MAX_WAIT-1).
- FSM, IDLE:
  - No mem_op: MEM/WB loads the inputs (readdata_out=0). Latency 1 cycle.
  - misaligned: no request, mem_err<=1, MEM/WB loads a bubble, stay IDLE.
  - mem_op with dmem_ready=1: completes in 1 cycle, MEM/WB loads (readdata_out=dmem_rdata on a load), stay IDLE.
  - mem_op with dmem_ready=0: go to WAIT, cnt<=0, MEM/WB loads a bubble.
- FSM, WAIT:
  - dmem_ready=1: complete as above, go to IDLE.
  - Else if timeout: abort, mem_err<=1, bubble, go to IDLE; upstream advances and the instruction is lost.
  - Else: cnt<=cnt+1, bubble.
- Bubble definition: regwrite_en_out=0 and MemtoReg_out=0; data fields hold their previous values.
- Stores never set regwrite_en_out, whatever regwrite_en_in says.
- dmem_ready while dmem_req=0 is ignored.
- mem_err clears only on reset.

Decomposition:
- Shared package pipe_pkg: state encoding (IDLE=1'b0, WAIT=1'b1), BUBBLE control constants, XLEN=32, REG_ADDR_W=5.
- One sub-module, mem_wb_reg: the plain MEM/WB register with a bubble input and the async active-low reset. The FSM, counter and handshake stay in the top.

Test Plan:
- ALU op (aluresult_in=0x1234, write_address_in=5, regwrite_en_in=1, no mem_op) -> next cycle aluresult_out=0x1234, write_address_out=5, regwrite_en_out=1, stall_out never 1.
- Load from 0x40 with dmem_ready tied 1 and dmem_rdata=0xDEADBEEF -> dmem_req=1 for 1 cycle, readdata_out=0xDEADBEEF, MemtoReg_out=1, no stall.
- Store to 0x44 with ready delayed 3 cycles -> stall_out=1 for exactly 3 cycles, dmem_we=1, dmem_wdata=data_b_in throughout, 3 bubbles, then regwrite_en_out=0 and state=IDLE.
- Load with ready never asserted, MAX_WAIT=8 -> stall_out=1 for 8 cycles, then mem_err=1, bubble, next instruction accepted.
- Load from 0x42 -> dmem_req stays 0, mem_err=1, bubble, no stall.
- Branch with zero_in=1, pc_in=0x100 -> pcsrc=1, branch_target=0x100. Assert reset=0 during a WAIT -> all outputs 0 immediately and dmem_req=0.
